// File: rtl/display_pkg.sv
// Shared types and helpers for the multiplexed BCD display scanner.
// Duty helper is only consumed when DISPLAY_SCANNER_BRIGHTNESS_EN is defined.
package display_pkg;

    localparam int BCD_W = 4;
    localparam int CNT_W = 16;

    typedef enum logic {
        ST_ON,
        ST_GUARD
    } scan_state_t;

    // Number of ON cycles a digit stays lit for brightness level b (0..7).
    function automatic logic [CNT_W-1:0] duty_thr(input logic [2:0] b, input int dwell);
        return CNT_W'(((int'(b) + 1) * dwell) / 8);
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Slot counter plus ON/GUARD phase FSM for the display scanner.
// Emits slot_start (last GUARD cycle), on_last and frame_end strobes.
module scan_timer import display_pkg::*; #(
    parameter int NUM_DIGITS = 4,
    parameter int DWELL      = 64,
    parameter int GUARD      = 4,
    parameter int IDX_W      = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output scan_state_t       state,
    output logic [CNT_W-1:0]  cnt,
    output logic [IDX_W-1:0]  nxt_idx,
    output logic              slot_start,
    output logic              on_last,
    output logic              frame_end
);

    localparam logic [IDX_W-1:0] MSD = IDX_W'(NUM_DIGITS - 1);

    scan_state_t      state_d;
    logic [CNT_W-1:0] cnt_d;
    logic [IDX_W-1:0] idx, idx_d;
    logic             started, started_d;

    // The guard after reset is a lead-in: it enters the MSD without decrementing.
    assign nxt_idx = !started ? idx : ((idx == '0) ? MSD : idx - 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_GUARD;
            cnt     <= '0;
            idx     <= MSD;
            started <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            idx     <= idx_d;
            started <= started_d;
        end
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt + 1'b1;
        idx_d     = idx;
        started_d = started;
        case (state)
            ST_ON: begin
                if (cnt == CNT_W'(DWELL - 1)) begin
                    state_d = ST_GUARD;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (cnt == CNT_W'(GUARD - 1)) begin
                    state_d   = ST_ON;
                    cnt_d     = '0;
                    idx_d     = nxt_idx;
                    started_d = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        slot_start = (state == ST_GUARD) && (cnt == CNT_W'(GUARD - 1));
        on_last    = (state == ST_ON) && (cnt == CNT_W'(DWELL - 1));
        frame_end  = slot_start && started && (idx == '0);
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// Multiplexed BCD scan controller driving one shared decoder with ripple blanking.
// Optional per-slot duty control is enabled with DISPLAY_SCANNER_BRIGHTNESS_EN.
module bcd_display_scanner import display_pkg::*; #(
    parameter int NUM_DIGITS = 4,
    parameter int DWELL      = 64,
    parameter int GUARD      = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        upd_valid,
    output logic                        upd_ready,
    input  logic [BCD_W*NUM_DIGITS-1:0] upd_data,
    input  logic                        lz_blank_en,
`ifdef DISPLAY_SCANNER_BRIGHTNESS_EN
    input  logic [2:0]                  bright,
`endif
    output logic [BCD_W-1:0]            bcd,
    output logic                        rbi,
    input  logic                        rbo_in,
    output logic [NUM_DIGITS-1:0]       digit_en,
    output logic                        frame_start
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] MSD = IDX_W'(NUM_DIGITS - 1);

    scan_state_t                 state;
    logic [CNT_W-1:0]            cnt;
    logic [CNT_W-1:0]            on_thr;
    logic [IDX_W-1:0]            nxt_idx;
    logic                        slot_start, on_last, frame_end, on_cut;
    logic [BCD_W*NUM_DIGITS-1:0] disp, shadow, disp_eff;
    logic                        pending, pending_d, accept, chain, slot_rbi;
    logic [NUM_DIGITS-1:0]       en_nxt;

    scan_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .DWELL      (DWELL),
        .GUARD      (GUARD),
        .IDX_W      (IDX_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .state      (state),
        .cnt        (cnt),
        .nxt_idx    (nxt_idx),
        .slot_start (slot_start),
        .on_last    (on_last),
        .frame_end  (frame_end)
    );

`ifdef DISPLAY_SCANNER_BRIGHTNESS_EN
    logic [2:0] bright_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          bright_q <= 3'd7;
        else if (slot_start) bright_q <= bright;
    end
    assign on_thr = duty_thr(bright_q, DWELL);
`else
    assign on_thr = CNT_W'(DWELL);
`endif

    assign on_cut = (state == ST_ON) && ((cnt + 1'b1) == on_thr);
    assign accept = upd_valid && !pending;
    // The MSD slot entry coincides with the boundary, so it must see the incoming frame.
    assign disp_eff = (frame_end && pending) ? shadow : disp;

    always_comb begin
        pending_d = pending;
        if (frame_end && pending) pending_d = 1'b0;
        else if (accept)          pending_d = 1'b1;
    end

    always_comb begin
        en_nxt          = '0;
        en_nxt[nxt_idx] = 1'b1;
        if (nxt_idx == MSD)      slot_rbi = ~lz_blank_en;
        else if (nxt_idx == '0)  slot_rbi = 1'b1;
        else                     slot_rbi = chain;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp      <= '0;
            shadow    <= '0;
            pending   <= 1'b0;
            upd_ready <= 1'b1;
        end else begin
            if (accept)               shadow <= upd_data;
            if (frame_end && pending) disp   <= shadow;
            pending   <= pending_d;
            upd_ready <= ~pending_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_en    <= '0;
            bcd         <= '0;
            rbi         <= 1'b1;
            frame_start <= 1'b0;
            chain       <= 1'b1;
        end else begin
            if (slot_start) begin
                digit_en    <= en_nxt;
                bcd         <= disp_eff[{nxt_idx, 2'b00} +: BCD_W];
                rbi         <= slot_rbi;
                frame_start <= (nxt_idx == MSD);
            end else begin
                frame_start <= 1'b0;
                if (on_cut || on_last) digit_en <= '0;
            end
            if (on_last) chain <= rbo_in;
        end
    end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner (4 digits, DWELL=8, GUARD=2, 40-cycle frame).
// Brightness steps are included when DISPLAY_SCANNER_BRIGHTNESS_EN is defined.
module tb_bcd_display_scanner;

    localparam int N     = 4;
    localparam int DWELL = 8;
    localparam int GUARD = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        upd_valid;
    logic        upd_ready;
    logic [15:0] upd_data;
    logic        lz_blank_en;
    logic [3:0]  bcd;
    logic        rbi;
    logic        rbo_in;
    logic [3:0]  digit_en;
    logic        frame_start;
`ifdef DISPLAY_SCANNER_BRIGHTNESS_EN
    logic [2:0]  bright;
`endif

    int checks   = 0;
    int failures = 0;
    int exp_thr  = DWELL;

    always #5 clk = ~clk;

    // Decoder model: RBO drops only when a zero is being blanked.
    assign rbo_in = !((rbi == 1'b0) && (bcd == 4'd0));

    bcd_display_scanner #(
        .NUM_DIGITS (N),
        .DWELL      (DWELL),
        .GUARD      (GUARD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .upd_valid   (upd_valid),
        .upd_ready   (upd_ready),
        .upd_data    (upd_data),
        .lz_blank_en (lz_blank_en),
`ifdef DISPLAY_SCANNER_BRIGHTNESS_EN
        .bright      (bright),
`endif
        .bcd         (bcd),
        .rbi         (rbi),
        .rbo_in      (rbo_in),
        .digit_en    (digit_en),
        .frame_start (frame_start)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts on the first ON cycle of the MSD and ends on the next one.
    task automatic check_frame(input logic [15:0] frame, input logic [3:0] rbi_exp,
                               input logic ready_mid, input logic drop_first,
                               input logic [15:0] nxt_data, input logic bnd_offer,
                               input logic [15:0] bnd_data);
        for (int s = 0; s < N; s++) begin
            int         d;
            logic [3:0] en_exp;
            d      = N - 1 - s;
            en_exp = 4'b0001 << d;
            for (int c = 0; c < DWELL; c++) begin
                chk("digit_en", {28'd0, digit_en}, (c < exp_thr) ? {28'd0, en_exp} : 32'd0);
                chk("frame_start", {31'd0, frame_start}, {31'd0, (s == 0 && c == 0)});
                if (c == 0) begin
                    chk("bcd", {28'd0, bcd}, {28'd0, frame[4*d +: 4]});
                    chk("rbi", {31'd0, rbi}, {31'd0, rbi_exp[d]});
                end
                if (s == 2 && c == 0) chk("upd_ready_mid", {31'd0, upd_ready}, {31'd0, ready_mid});
                @(posedge clk); #1;
                if (s == 0 && c == 0) begin
                    if (drop_first) upd_valid = 1'b0;
                    else            upd_data  = nxt_data;
                end
            end
            for (int g = 0; g < GUARD; g++) begin
                chk("guard_en", {28'd0, digit_en}, 32'd0);
                if (bnd_offer && s == N - 1 && g == GUARD - 1) begin
                    upd_valid = 1'b1;
                    upd_data  = bnd_data;
                end
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        upd_valid   = 1'b0;
        upd_data    = 16'h0000;
        lz_blank_en = 1'b0;
`ifdef DISPLAY_SCANNER_BRIGHTNESS_EN
        bright      = 3'd7;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_digit_en", {28'd0, digit_en}, 32'd0);
        chk("rst_bcd", {28'd0, bcd}, 32'd0);
        chk("rst_rbi", {31'd0, rbi}, 32'd1);
        chk("rst_frame_start", {31'd0, frame_start}, 32'd0);
        chk("rst_upd_ready", {31'd0, upd_ready}, 32'd1);

        // Frame 0x1234 offered right at reset release.
        upd_valid = 1'b1;
        upd_data  = 16'h1234;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("lead_guard_en", {28'd0, digit_en}, 32'd0);
        chk("accept_ready", {31'd0, upd_ready}, 32'd0);
        @(posedge clk); #1;
        chk("first_on", {28'd0, digit_en}, 32'h8);
        upd_valid = 1'b0;
        check_frame(16'h0000, 4'b1111, 1'b0, 1'b0, 16'h1234, 1'b0, 16'h0);
        chk("ready_after_boundary", {31'd0, upd_ready}, 32'd1);

        // Leading-zero blanking; lz change lands at the next MSD entry.
        lz_blank_en = 1'b1; upd_valid = 1'b1; upd_data = 16'h0040;
        check_frame(16'h1234, 4'b1111, 1'b0, 1'b1, 16'h0, 1'b0, 16'h0);
        upd_valid = 1'b1; upd_data = 16'h0400;
        check_frame(16'h0040, 4'b0001, 1'b0, 1'b1, 16'h0, 1'b0, 16'h0);
        upd_valid = 1'b1; upd_data = 16'h0000;
        check_frame(16'h0400, 4'b0011, 1'b0, 1'b1, 16'h0, 1'b0, 16'h0);
        lz_blank_en = 1'b0; upd_valid = 1'b1; upd_data = 16'h0040;
        check_frame(16'h0000, 4'b0001, 1'b0, 1'b1, 16'h0, 1'b0, 16'h0);

        // Back-to-back offers: second waits for the boundary.
        upd_valid = 1'b1; upd_data = 16'h5678;
        check_frame(16'h0040, 4'b1111, 1'b0, 1'b0, 16'h9abc, 1'b0, 16'h0);
        chk("ready_b2b", {31'd0, upd_ready}, 32'd1);
        check_frame(16'h5678, 4'b1111, 1'b0, 1'b1, 16'h0, 1'b0, 16'h0);

        // Accept on the boundary cycle itself: applied one frame later.
        check_frame(16'h9abc, 4'b1111, 1'b1, 1'b0, 16'h9abc, 1'b1, 16'h0102);
        upd_valid = 1'b0;
        chk("ready_bnd_accept", {31'd0, upd_ready}, 32'd0);
        check_frame(16'h9abc, 4'b1111, 1'b0, 1'b0, 16'h0102, 1'b0, 16'h0);
        check_frame(16'h0102, 4'b1111, 1'b1, 1'b0, 16'h0102, 1'b0, 16'h0);

        // Reset mid-ON of the third slot with a frame pending.
        upd_valid = 1'b1; upd_data = 16'h7777;
        @(posedge clk); #1;
        upd_valid = 1'b0;
        repeat (22) @(posedge clk);
        #1;
        chk("pre_reset_en", {28'd0, digit_en}, 32'h2);
        chk("pre_reset_ready", {31'd0, upd_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("async_rst_en", {28'd0, digit_en}, 32'd0);
        chk("async_rst_ready", {31'd0, upd_ready}, 32'd1);
        chk("async_rst_bcd", {28'd0, bcd}, 32'd0);
        chk("async_rst_rbi", {31'd0, rbi}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_guard_en", {28'd0, digit_en}, 32'd0);
        @(posedge clk); #1;
        chk("rel_first_on", {28'd0, digit_en}, 32'h8);
        check_frame(16'h0000, 4'b1111, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
        check_frame(16'h0000, 4'b1111, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0);

`ifdef DISPLAY_SCANNER_BRIGHTNESS_EN
        bright = 3'd3;
        repeat (N * (DWELL + GUARD)) @(posedge clk);
        #1;
        exp_thr = 4;
        check_frame(16'h0000, 4'b1111, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
        bright = 3'd7;
        repeat (N * (DWELL + GUARD)) @(posedge clk);
        #1;
        exp_thr = 8;
        check_frame(16'h0000, 4'b1111, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
